// File: rtl/neighbor_link_bank.sv
// Bank of weighted union-find neighbor links, stepped by the decoder-wide stage.
// Optional NEIGHBOR_LINK_SHRINK_EN adds shrink requests and non-monotonic growth.
module neighbor_link_cell #(
  parameter int WEIGHT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic                    grow_en,
  input  logic [WEIGHT_WIDTH-1:0] weight_in,
  input  logic                    grow_a,
  input  logic                    grow_b,
`ifdef NEIGHBOR_LINK_SHRINK_EN
  input  logic                    shrink_a,
  input  logic                    shrink_b,
`endif
  output logic                    fully_grown,
  output logic                    newly_grown
);
  logic [WEIGHT_WIDTH-1:0] weight, growth, growth_next;
  logic [WEIGHT_WIDTH:0]   inc, sum;
  logic                    loaded, grown_next;
`ifdef NEIGHBOR_LINK_SHRINK_EN
  logic [WEIGHT_WIDTH:0]   dec, diff;
`endif

  always_comb begin
    inc = {{WEIGHT_WIDTH{1'b0}}, grow_a} + {{WEIGHT_WIDTH{1'b0}}, grow_b};
    sum = {1'b0, growth} + inc;
`ifdef NEIGHBOR_LINK_SHRINK_EN
    dec  = {{WEIGHT_WIDTH{1'b0}}, shrink_a} + {{WEIGHT_WIDTH{1'b0}}, shrink_b};
    diff = (sum > dec) ? sum - dec : '0;
    growth_next = (diff >= {1'b0, weight}) ? weight : diff[WEIGHT_WIDTH-1:0];
`else
    // saturation also makes an already-full link ignore further growth
    growth_next = (sum >= {1'b0, weight}) ? weight : sum[WEIGHT_WIDTH-1:0];
`endif
    // a link never loaded since reset cannot report grown, even at weight 0
    grown_next = loaded && (growth_next == weight);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weight      <= '0;
      growth      <= '0;
      loaded      <= 1'b0;
      fully_grown <= 1'b0;
      newly_grown <= 1'b0;
    end else begin
      newly_grown <= 1'b0;
      if (load_en) begin
        weight      <= weight_in;
        growth      <= '0;
        loaded      <= 1'b1;
        fully_grown <= (weight_in == '0);
      end else if (grow_en) begin
        growth      <= growth_next;
        fully_grown <= grown_next;
        newly_grown <= grown_next & ~fully_grown;
      end
    end
  end
endmodule

module neighbor_link_bank #(
  parameter int NUM_LINKS                 = 4,
  parameter int WEIGHT_WIDTH              = 3,
  parameter int STAGE_WIDTH               = 3,
  parameter int STAGE_IDLE                = 0,
  parameter int STAGE_MEASUREMENT_LOADING = 1,
  parameter int STAGE_GROW                = 2,
  parameter int STAGE_WRITE_TO_MEM        = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [STAGE_WIDTH-1:0]            global_stage,
  input  logic [NUM_LINKS*WEIGHT_WIDTH-1:0] weight_in,
  input  logic [NUM_LINKS-1:0]              grow_a,
  input  logic [NUM_LINKS-1:0]              grow_b,
`ifdef NEIGHBOR_LINK_SHRINK_EN
  input  logic [NUM_LINKS-1:0]              shrink_a,
  input  logic [NUM_LINKS-1:0]              shrink_b,
`endif
  output logic [NUM_LINKS-1:0]              fully_grown,
  output logic [NUM_LINKS-1:0]              newly_grown,
  output logic [NUM_LINKS-1:0]              fully_grown_mem
);
  logic [STAGE_WIDTH-1:0] stage, last_stage;
  logic entry, load_en, grow_en, mem_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage      <= STAGE_WIDTH'(STAGE_IDLE);
      last_stage <= STAGE_WIDTH'(STAGE_IDLE);
    end else begin
      stage      <= global_stage;
      last_stage <= stage;
    end
  end

  // each stage action fires once, on the first cycle of a stage visit
  assign entry   = (stage != last_stage);
  assign load_en = entry && (stage == STAGE_WIDTH'(STAGE_MEASUREMENT_LOADING));
  assign grow_en = entry && (stage == STAGE_WIDTH'(STAGE_GROW));
  assign mem_en  = entry && (stage == STAGE_WIDTH'(STAGE_WRITE_TO_MEM));

  always_ff @(posedge clk) begin
    if (reset)       fully_grown_mem <= '0;
    else if (mem_en) fully_grown_mem <= fully_grown;
  end

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
    neighbor_link_cell #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_cell (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .grow_en     (grow_en),
      .weight_in   (weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .grow_a      (grow_a[i]),
      .grow_b      (grow_b[i]),
`ifdef NEIGHBOR_LINK_SHRINK_EN
      .shrink_a    (shrink_a[i]),
      .shrink_b    (shrink_b[i]),
`endif
      .fully_grown (fully_grown[i]),
      .newly_grown (newly_grown[i])
    );
  end
endmodule

// File: tb/tb_neighbor_link_bank.sv
// Randomized bench for neighbor_link_bank against an event-level link model.
module tb_neighbor_link_bank;
  localparam int IDLE = 0, LOAD = 1, GROW = 2, WTM = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  global_stage;
  logic [11:0] weight_in;
  logic [3:0]  grow_a, grow_b;
`ifdef NEIGHBOR_LINK_SHRINK_EN
  logic [3:0]  shrink_a = '0, shrink_b = '0;
`endif
  logic [3:0]  fully_grown, newly_grown, fully_grown_mem;

  int checks = 0;
  int errors = 0;

  // model: weight/growth per link, whether loaded since reset, outputs
  int         mw[4], mg[4];
  bit         ml[4];
  logic [3:0] m_fg, m_nw, m_mem;
  int         p1, p2;   // stage codes driven one and two cycles ago

  neighbor_link_bank dut (
    .clk             (clk),
    .reset           (reset),
    .global_stage    (global_stage),
    .weight_in       (weight_in),
    .grow_a          (grow_a),
    .grow_b          (grow_b),
`ifdef NEIGHBOR_LINK_SHRINK_EN
    .shrink_a        (shrink_a),
    .shrink_b        (shrink_b),
`endif
    .fully_grown     (fully_grown),
    .newly_grown     (newly_grown),
    .fully_grown_mem (fully_grown_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input int stg, input logic [3:0] ga,
                            input logic [3:0] gb, input logic [11:0] w);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mw[i] = 0; mg[i] = 0; ml[i] = 0; end
      m_fg = '0; m_nw = '0; m_mem = '0; p1 = IDLE; p2 = IDLE;
      return;
    end
    m_nw = '0;
    if (p1 != p2) begin
      if (p1 == LOAD) begin
        for (int i = 0; i < 4; i++) begin
          mw[i] = int'((w >> (3*i)) & 12'h7);
          mg[i] = 0; ml[i] = 1;
          m_fg[i] = (mw[i] == 0);
        end
      end else if (p1 == GROW) begin
        for (int i = 0; i < 4; i++) begin
          bit nf;
          mg[i] = mg[i] + int'(ga[i]) + int'(gb[i]);
          if (mg[i] > mw[i]) mg[i] = mw[i];
          nf = ml[i] && (mg[i] >= mw[i]);
          m_nw[i] = nf && !m_fg[i];
          m_fg[i] = nf;
        end
      end else if (p1 == WTM) begin
        m_mem = m_fg;
      end
    end
    p2 = p1; p1 = stg;
  endtask

  task automatic cyc(input logic rst, input int stg, input logic [3:0] ga,
                     input logic [3:0] gb, input logic [11:0] w);
    reset = rst; global_stage = 3'(stg); grow_a = ga; grow_b = gb; weight_in = w;
    @(posedge clk);
    model_edge(rst, stg, ga, gb, w);
    @(negedge clk);
    chk("fully_grown", {28'd0, fully_grown}, {28'd0, m_fg});
    chk("newly_grown", {28'd0, newly_grown}, {28'd0, m_nw});
    chk("fully_grown_mem", {28'd0, fully_grown_mem}, {28'd0, m_mem});
  endtask

  initial begin
    logic [11:0] w_a, w_7;
    int stg;
    w_a = {3'd3, 3'd2, 3'd1, 3'd0};
    w_7 = 12'hfff;
    p1 = IDLE; p2 = IDLE; m_fg = '0; m_nw = '0; m_mem = '0;

    cyc(1, IDLE, 0, 0, 0);
    cyc(1, IDLE, 0, 0, 0);
    repeat (5) cyc(0, IDLE, 0, 0, 0);
    chk("plan_reset_fg", {28'd0, fully_grown}, 32'h0);

    repeat (2) cyc(0, LOAD, 0, 0, w_a);
    cyc(0, IDLE, 0, 0, w_a);
    chk("plan_load_fg", {28'd0, fully_grown}, 32'h1);

    cyc(0, GROW, 4'b1111, 4'b0010, 0);
    cyc(0, GROW, 4'b1111, 4'b0010, 0);
    chk("plan_grow_pulse", {28'd0, newly_grown}, 32'h2);
    repeat (10) cyc(0, GROW, 4'b1111, 4'b0000, 0);
    chk("plan_grow_hold_fg", {28'd0, fully_grown}, 32'h3);
    chk("plan_grow_hold_nw", {28'd0, newly_grown}, 32'h0);

    cyc(0, IDLE, 0, 0, 0);
    repeat (2) cyc(0, GROW, 4'b1111, 4'b1111, 0);
    cyc(0, IDLE, 0, 0, 0);
    repeat (2) cyc(0, GROW, 4'b1111, 4'b1111, 0);
    cyc(0, IDLE, 0, 0, 0);
    chk("plan_saturate_fg", {28'd0, fully_grown}, 32'hf);

    repeat (2) cyc(0, WTM, 0, 0, 0);
    cyc(0, IDLE, 0, 0, 0);
    chk("plan_mem", {28'd0, fully_grown_mem}, 32'hf);
    repeat (2) cyc(0, LOAD, 0, 0, w_7);
    cyc(0, IDLE, 0, 0, 0);
    chk("plan_reload_fg", {28'd0, fully_grown}, 32'h0);
    chk("plan_reload_mem", {28'd0, fully_grown_mem}, 32'hf);

    cyc(0, GROW, 4'b1111, 4'b1111, 0);
    cyc(1, GROW, 4'b1111, 4'b1111, 0);
    chk("plan_midreset_fg", {28'd0, fully_grown}, 32'h0);
    chk("plan_midreset_mem", {28'd0, fully_grown_mem}, 32'h0);
    cyc(0, IDLE, 0, 0, 0);
    repeat (3) cyc(0, GROW, 4'b1111, 4'b1111, 0);
    chk("plan_noload_fg", {28'd0, fully_grown}, 32'h0);

    stg = IDLE;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    stg = IDLE;
        2, 3:    stg = LOAD;
        4, 5, 6: stg = GROW;
        7:       stg = WTM;
        8:       stg = 3;
        default: ;
      endcase
      cyc(($urandom_range(0, 99) == 0), stg, 4'($urandom), 4'($urandom),
          12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
